// File: rtl/mem_access_unit.sv
// Load/store sequencer between execute and the word-addressed dmemory; sub-word stores use read-modify-write.
// Optional alignment trap: define MEM_ALIGN_TRAP_EN to complete misaligned half/word accesses without memory traffic.
module mem_access_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              dclk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W+1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              misalign,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              state_q;
    state_t              start_st;
    logic                we_q;
    logic                sext_q;
    logic                misalign_q;
    logic [1:0]          size_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                mis_in;
    logic [4:0]          byte_sh;
    logic [4:0]          half_sh;
    logic [7:0]          byte_lane;
    logic [15:0]         half_lane;
    logic [DATA_W-1:0]   rdata_d;
    logic [DATA_W-1:0]   merge_d;

`ifdef MEM_ALIGN_TRAP_EN
    assign mis_in = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
`else
    assign mis_in = 1'b0;
`endif

    always_comb begin
        if (mis_in) begin
            start_st = S_DONE;
        end else if (we && size[1]) begin
            start_st = S_WR;
        end else begin
            start_st = S_RD;
        end
    end

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        byte_sh   = {~addr_q[1:0], 3'b000};
        half_sh   = {~addr_q[1], 4'b0000};
        byte_lane = mem_rdata[byte_sh +: 8];
        half_lane = mem_rdata[half_sh +: 16];
        rdata_d   = mem_rdata;
        merge_d   = mem_rdata;
        case (size_q)
            2'b00: begin
                rdata_d = {{24{sext_q & byte_lane[7]}}, byte_lane};
                merge_d[byte_sh +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                rdata_d = {{16{sext_q & half_lane[15]}}, half_lane};
                merge_d[half_sh +: 16] = wdata_q[15:0];
            end
            default: begin
                rdata_d = mem_rdata;
                merge_d = wdata_q;
            end
        endcase
    end

    always_ff @(posedge dclk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            sext_q      <= 1'b0;
            misalign_q  <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (req) begin
                        we_q       <= we;
                        sext_q     <= sign_ext;
                        size_q     <= size;
                        addr_q     <= addr;
                        wdata_q    <= wdata;
                        misalign_q <= mis_in;
                        if (we && size[1] && !mis_in) begin
                            mem_wdata_q <= wdata;
                        end
                        state_q <= start_st;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RD: state_q <= S_WAIT;
                S_WAIT: begin
                    if (we_q) begin
                        mem_wdata_q <= merge_d;
                        state_q     <= S_WR;
                    end else begin
                        rdata_q <= rdata_d;
                        state_q <= S_DONE;
                    end
                end
                S_WR: state_q <= S_DONE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q == S_RD) || (state_q == S_WAIT) || (state_q == S_WR);
    assign done      = (state_q == S_DONE);
    assign misalign  = done & misalign_q;
    assign mem_read  = (state_q == S_RD);
    assign mem_write = (state_q == S_WR);
    assign mem_addr  = (mem_read || mem_write) ? addr_q[ADDR_W+1:2] : '0;
    assign rdata     = rdata_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random traffic against a word-array reference model.
module tb_mem_access_unit;

    logic        dclk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [9:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, misalign, mem_read, mem_write;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;
    logic        preload = 1'b1;

    logic [31:0] mem_arr [256];
    logic [31:0] ref_mem [256];
    logic [31:0] exp_rdata = '0;
    logic [31:0] last_wr_data = '0;
    int          n_tests = 0;
    int          n_fail = 0;

`ifdef MEM_ALIGN_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    mem_access_unit dut (
        .dclk(dclk), .reset(reset), .req(req), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
        .done(done), .rdata(rdata), .misalign(misalign), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    always #5 dclk = ~dclk;

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5AC3C3;
    endfunction

    // Synchronous single-port RAM standing in for dmemory.
    always @(posedge dclk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(i);
        end else if (mem_write) begin
            mem_arr[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem_arr[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_mis(input logic [1:0] sz, input logic [9:0] a);
        return TRAP_ON && (((sz == 2'b01) && a[0]) || ((sz >= 2'b10) && (a[1:0] != 2'b00)));
    endfunction

    function automatic logic [31:0] load_model(input logic [31:0] word, input logic [1:0] sz,
                                               input logic sx, input logic [9:0] a);
        logic [31:0] v;
        int sh;
        if (sz == 2'b00) begin
            sh = 8 * (3 - int'(a[1:0]));
            v = (word >> sh) & 32'hFF;
            if (sx && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (sz == 2'b01) begin
            sh = a[1] ? 0 : 16;
            v = (word >> sh) & 32'hFFFF;
            if (sx && v >= 32'h8000) v = v + 32'hFFFF0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] store_model(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [9:0] a, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (sz == 2'b00) begin
            sh = 8 * (3 - int'(a[1:0]));
            mask = 32'hFF << sh;
            return (word & ~mask) | ((wd & 32'hFF) << sh);
        end
        sh = a[1] ? 0 : 16;
        mask = 32'hFFFF << sh;
        return (word & ~mask) | ((wd & 32'hFFFF) << sh);
    endfunction

    task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [9:0] a, input logic [31:0] wd);
        logic [31:0] old_w, new_w, wdat;
        logic [7:0]  wa;
        bit          mis, got_done;
        int          exp_lat, exp_rd, exp_wr, n_rd, n_wr, cyc;
        old_w = ref_mem[a[9:2]];
        new_w = old_w;
        mis = model_mis(sz, a);
        exp_wr = 0;
        if (mis) begin
            exp_lat = 1; exp_rd = 0;
        end else if (w && sz[1]) begin
            exp_lat = 2; exp_rd = 0; exp_wr = 1; new_w = wd;
        end else if (w) begin
            exp_lat = 4; exp_rd = 1; exp_wr = 1; new_w = store_model(old_w, sz, a, wd);
        end else begin
            exp_lat = 3; exp_rd = 1; exp_rdata = load_model(old_w, sz, sx, a);
        end
        @(negedge dclk);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge dclk);
        #1;
        req = 1'b0; we = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
        addr = 10'($urandom); wdata = $urandom;
        n_rd = 0; n_wr = 0; cyc = 0; got_done = 0; wa = '0; wdat = '0;
        while (!got_done && cyc < 10) begin
            @(negedge dclk);
            cyc++;
            if (mem_read) begin
                n_rd++;
                chk("rd_addr", 32'(mem_addr), 32'(a[9:2]));
            end
            if (mem_write) begin
                n_wr++; wa = mem_addr; wdat = mem_wdata;
            end
            chk("busy", 32'(busy), 32'(cyc < exp_lat));
            if (done) got_done = 1;
        end
        if (got_done) chk("latency", cyc, exp_lat);
        else chk("timeout_done", 32'(got_done), 32'd1);
        chk("misalign", 32'(misalign), 32'(mis));
        chk("rdata", rdata, exp_rdata);
        chk("n_read", n_rd, exp_rd);
        chk("n_write", n_wr, exp_wr);
        if (exp_wr == 1 && n_wr == 1) begin
            chk("wr_addr", 32'(wa), 32'(a[9:2]));
            chk("wr_data", wdat, new_w);
            last_wr_data = wdat;
        end
        ref_mem[a[9:2]] = new_w;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] e1, e2;
        logic [7:0]  dmask;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        repeat (3) @(posedge dclk);
        @(negedge dclk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_wr", 32'(mem_write), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        preload = 1'b0;
        reset = 1'b1;

        // Abort a word store while its write strobe is up.
        @(negedge dclk);
        req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 10'h020; wdata = 32'hCAFEF00D;
        @(posedge dclk);
        #1 req = 1'b0;
        @(negedge dclk);
        chk("abort_pre_wr", 32'(mem_write), 1);
        chk("abort_pre_addr", 32'(mem_addr), 32'h08);
        chk("abort_pre_wdata", mem_wdata, 32'hCAFEF00D);
        reset = 1'b0;
        #1;
        chk("abort_mem_write", 32'(mem_write), 0);
        chk("abort_mem_read", 32'(mem_read), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_misalign", 32'(misalign), 0);
        chk("abort_mem_addr", 32'(mem_addr), 0);
        chk("abort_mem_wdata", mem_wdata, 0);
        chk("abort_rdata", rdata, 0);
        @(negedge dclk);
        reset = 1'b1;
        exp_rdata = '0;

        access(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF);
        access(1'b0, 2'b10, 1'b0, 10'h010, 32'h0);
        chk("lw_deadbeef", rdata, 32'hDEADBEEF);

        access(1'b1, 2'b10, 1'b0, 10'h010, 32'h11223344);
        access(1'b1, 2'b00, 1'b0, 10'h012, 32'h000000AA);
        chk("sb_merge", last_wr_data, 32'h1122AA44);

        access(1'b1, 2'b10, 1'b0, 10'h010, 32'h80FF7F01);
        access(1'b0, 2'b00, 1'b1, 10'h010, 32'h0);
        chk("lb_off0_sx", rdata, 32'hFFFFFF80);
        access(1'b0, 2'b00, 1'b0, 10'h012, 32'h0);
        chk("lbu_off2", rdata, 32'h0000007F);
        access(1'b0, 2'b01, 1'b1, 10'h012, 32'h0);
        chk("lh_off2_sx", rdata, 32'h00007F01);

        access(1'b0, 2'b10, 1'b0, 10'h013, 32'h0);

        // Back-to-back loads with req held through the first DONE.
        e1 = load_model(ref_mem[4], 2'b10, 1'b0, 10'h010);
        e2 = load_model(ref_mem[4], 2'b01, 1'b1, 10'h010);
        dmask = '0;
        @(negedge dclk);
        req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 10'h010;
        @(posedge dclk);
        for (int c = 1; c <= 7; c++) begin
            @(negedge dclk);
            if (c == 1) begin size = 2'b01; sign_ext = 1'b1; end
            if (c == 4) begin
                req = 1'b0;
                chk("b2b_rd_after_done", 32'(mem_read), 1);
            end
            if (done) dmask[c-1] = 1'b1;
            if (c == 3) chk("b2b_rdata1", rdata, e1);
            if (c == 6) chk("b2b_rdata2", rdata, e2);
        end
        chk("b2b_done_cycles", 32'(dmask), 32'b0010_0100);
        exp_rdata = e2;

        for (int n = 0; n < 150; n++) begin
            access(1'($urandom), 2'($urandom), 1'($urandom), 10'($urandom_range(0, 63)), $urandom);
        end

        repeat (2) @(negedge dclk);
        for (int i = 0; i < 16; i++) chk("mem_final", mem_arr[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer sitting between the execute stage and the `dmemory` data-memory wrapper. It takes a byte-addressed load or store request of byte, halfword or word size, drives the word-addressed single-port memory, and returns aligned, sign- or zero-extended load data. Sub-word stores are done as read-modify-write, because the memory has a single whole-word write enable. A busy output stalls the pipeline while an access is in flight.

## Interface
Parameters:
- `ADDR_W`, 8: word-address width to `dmemory`. The byte address is `ADDR_W+2` bits.
- `DATA_W`, 32: data width. Fixed at 32; other values are not supported.

Ports:
- `dclk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  request strobe from execute; sampled only when `busy`=0.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `sign_ext`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `addr`  in  10  byte address. [9:2] is the word, [1:0] is the byte offset.
- `wdata`  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- `busy`  out  1  high in RD, WAIT and WR states.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  registered load result; held until the next load completes.
- `misalign`  out  1  valid with `done`; see Configuration.
- `mem_addr`  out  8  word address to `dmemory`.
- `mem_wdata`  out  32  write data to `dmemory`.
- `mem_read`  out  1  read strobe to `dmemory`.
- `mem_write`  out  1  write enable to `dmemory`.
- `mem_rdata`  in  32  read data from `dmemory`, valid one cycle after the address is presented (synchronous RAM).

## Operation
- FSM states: IDLE, RD, WAIT, WR, DONE. The state register is asynchronously reset to IDLE.
- Acceptance:
  - `req`=1 is accepted on the rising edge while in IDLE or DONE.
  - On acceptance, `we`, `size`, `sign_ext`, `addr` and `wdata` are latched. Later input changes are ignored until the next acceptance.
- Transitions from acceptance:
  - load or sub-word store goes to RD
  - word store goes to WR
  - misaligned access with the trap enabled goes to DONE
- State actions:
  - RD: `mem_addr` = latched addr[9:2], `mem_read`=1; next state WAIT.
  - WAIT, load: extract the lane from `mem_rdata`, extend it, register it into `rdata`; next state DONE.
  - WAIT, store: merge `wdata` into the lane of `mem_rdata` and register it into `mem_wdata`; next state WR.
  - WR: `mem_write`=1 with `mem_addr` and `mem_wdata`; next state DONE.
  - DONE: `done`=1. Next state is the new request's start state if `req`=1, else IDLE.
- Lane mapping is big-endian:
  - byte offsets 0/1/2/3 map to bits [31:24]/[23:16]/[15:8]/[7:0]
  - half offset 0 maps to [31:16]; half offset 2 maps to [15:0]
- Word store: `mem_wdata` = `wdata` is loaded on acceptance.
- `mem_read`, `mem_write` and `mem_addr` decode from the state register only. They are never high outside RD/WR, and `mem_addr`=0 in IDLE.
- Reset:
  - every output is 0, `rdata`=0 and the latches are 0
  - reset mid-access aborts the access with no write; `mem_write` falls asynchronously with the state

## Timing
- Edge E0 is the acceptance edge.
- Load: RD in cycle 1, WAIT in cycle 2, `done` in cycle 3. `rdata` is valid from cycle 3.
- Word store: WR in cycle 1, `done` in cycle 2.
- Sub-word store: RD in cycle 1, WAIT in cycle 2, WR in cycle 3, `done` in cycle 4.
- Back-to-back: a `req` held during DONE is accepted there, so there is no IDLE bubble.
- `busy` is combinational from the state and low in IDLE and DONE.

## Configuration
- `MEM_ALIGN_TRAP_EN` defined:
  - a half access with addr[0]=1, or a word access with addr[1:0]≠0, goes straight to DONE
  - no memory strobes are issued
  - `misalign`=1 with `done`; `rdata` is unchanged
- `MEM_ALIGN_TRAP_EN` undefined:
  - a half access ignores addr[0]; a word access ignores addr[1:0]
  - `misalign` is tied to 0

## Test plan
- Reset with `reset`=0 mid-WR of a word store → `mem_write` drops immediately and all outputs read 0.
- Word store of 0xDEADBEEF to addr 0x010, then load word from 0x010 → `mem_write` is seen at word 0x04, `done` occurs 2 cycles after acceptance, and the load gives `rdata`=0xDEADBEEF at cycle 3.
- Memory word 0x04 = 0x11223344, then byte store of 0xAA at addr 0x012 → a read followed by a write of 0x1122AA44, with `done` at cycle 4.
- Memory word = 0x80FF7F01:
  - lb at offset 0 with `sign_ext`=1 → `rdata`=0xFFFFFF80
  - lbu at offset 2 → 0x0000007F
  - lh at offset 2 with `sign_ext`=1 → 0x00007F01
- Two loads with `req` held high through DONE → the second RD immediately follows the first DONE, and `done` pulses at cycles 3 and 6.
- With `MEM_ALIGN_TRAP_EN` defined, load word from addr 0x013 → `done`=1 and `misalign`=1 at cycle 1, with no `mem_read`. With it undefined, the same load reads word 0x04 and `misalign`=0.
